tan_coef_streamer: RTL
======================

// Module: tan_coef_streamer
// PURPOSE
//  Parametrised successor to the fixed 8-entry tan-series coefficient table.
//  Holds the Taylor coefficients c_k of tan(x) as Q0.32 constants.
//  Streams them out at Q0.DATA_W precision over a valid/ready handshake:
//   - ascending order: k = 0..TERMS-1, for power-sum evaluation;
//   - descending order: k = TERMS-1..0, for Horner evaluation.
//  Sits between the tan accelerator controller (start/done) and its MAC datapath.
// PARAMETERS
//  DATA_W  16  output fraction width, Q0.DATA_W; legal 8..32
//  TERMS    8  coefficients per burst; legal 2..8
//  IDX_W    3  index width; must be >= $clog2(TERMS)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       burst request; sampled in IDLE only
//  descend    in   1       order select, captured at start: 0 = ascending, 1 = descending
//  busy       out  1       high from the cycle after an accepted start until burst end
//  out_valid  out  1       out_data, out_idx and out_last are valid
//  out_ready  in   1       consumer accepts the beat; transfer = out_valid & out_ready
//  out_data   out  DATA_W  coefficient c_k, Q0.DATA_W
//  out_idx    out  IDX_W   k of the current beat
//  out_last   out  1       current beat is the final beat of the burst
//  done       out  1       one-cycle pulse after the final transfer
// BEHAVIOUR
//  Reset: busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0; FSM enters IDLE.
//  Reset is asynchronous and may assert at any time; a burst in progress is abandoned, no done.
//  Table (k: c_k; entry = floor(c_k * 2^32)):
//   0: 0 (the x term is handled by the datapath)   1: 1/3        2: 2/15
//   3: 17/315          4: 62/2835          5: 1382/155925
//   6: 21844/6081075   7: 929569/638512875
//  Entries with k >= TERMS are never emitted.
//  Width: out_data = entry[31 -: DATA_W] (truncate); see CONFIGURATION for rounding.
//  FSM has two states, IDLE and STREAM.
//  IDLE & start:
//   - capture descend;
//   - load k = descend ? TERMS-1 : 0;
//   - go to STREAM;
//   - next cycle: busy=1, out_valid=1, first beat presented (1-cycle latency).
//  STREAM, normal beat:
//   - out_valid stays high;
//   - out_data, out_idx and out_last are held stable while out_valid & !out_ready;
//   - on a transfer, the next k is registered and presented the following cycle;
//   - sustains 1 beat/cycle while out_ready=1.
//  out_last = 1 when k == TERMS-1 (ascending) or k == 0 (descending).
//  STREAM, transfer with out_last=1:
//   - next cycle: out_valid=0, busy=0, done=1 for one cycle;
//   - FSM returns to IDLE.
//  start is ignored while busy=1, including the cycle of the final transfer.
//   A new start is accepted from the cycle done=1 onward (FSM is in IDLE then).
//  start and descend are don't-care in STREAM; descend changes mid-burst have no effect.
//  out_ready is don't-care while out_valid=0.
//  In IDLE, out_data and out_idx retain their last values; only out_valid qualifies them.
// CONFIGURATION
//  TAN_COEF_ROUND_EN defined:
//   - out_data = round-half-up(entry >> (32-DATA_W));
//   - the rounding add cannot overflow (max c_k < 0.34);
//   - when DATA_W=32, identical to truncation.
//  TAN_COEF_ROUND_EN undefined: truncation as above.
//  The macro does not change latency or handshake.
// TESTING (DATA_W=16, TERMS=8 unless stated)
//  1 Reset:
//    rst_n=0 -> all outputs 0; busy=0.
//    Release, no start for 10 cycles -> out_valid stays 0.
//  2 Ascending, out_ready=1, start pulse, no macro:
//    - beats 0000,5555,2222,0DD0,0599,0244,00EB,005F on 8 consecutive cycles;
//    - out_idx 0..7; out_last only on beat 7;
//    - done=1 exactly one cycle after beat 7.
//  3 Descending, out_ready toggling 1,0,1,0:
//    - order 005F,00EB,...,0000 (out_idx 7..0);
//    - each beat held stable while out_ready=0;
//    - no beat duplicated or dropped.
//  4 Macro TAN_COEF_ROUND_EN:
//    - ascending burst -> k3=0DD1, k5=0245, k6=00EB, k7=005F;
//    - all other beats unchanged.
//  5 Back-to-back and ignored start:
//    - start held high throughout -> second burst starts the cycle after done;
//    - start pulsed mid-burst -> ignored, burst length stays 8;
//    - TERMS=4 -> 4 beats, out_last on k=3.
//  6 Reset mid-burst:
//    - rst_n=0 after beat 3 -> out_valid=0, busy=0 immediately, no done;
//    - new start after release -> burst restarts at k=0.

Source files
------------

// File: rtl/tan_coef_streamer.sv
// Streams tan(x) Taylor coefficients c_k (Q0.DATA_W) over valid/ready.
// Define TAN_COEF_ROUND_EN for round-half-up instead of truncation.
module tan_coef_streamer #(
  parameter int DATA_W = 16,
  parameter int TERMS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              descend,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              done
);

  typedef enum logic {IDLE, STREAM} state_t;

  // floor(c_k * 2^32)
  localparam logic [31:0] TAB [8] = '{
    32'h0000_0000, 32'h5555_5555,
    32'h2222_2222, 32'h0DD0_DD0D,
    32'h0599_3D22, 32'h0244_DC6A,
    32'h00EB_69E8, 32'h005F_68D9
  };

  localparam logic [IDX_W-1:0] K_MAX =
    IDX_W'(TERMS - 1);

  function automatic logic [DATA_W-1:0] coef(
    input logic [IDX_W-1:0] k
  );
    logic [31:0] e;
`ifdef TAN_COEF_ROUND_EN
    logic [32:0] s;
`endif
    e = TAB[3'(k)];
`ifdef TAN_COEF_ROUND_EN
    // pad one bit so the half-LSB add also works at DATA_W=32
    s = {e, 1'b0} + (33'd1 << (32 - DATA_W));
    return s[32 -: DATA_W];
`else
    return e[31 -: DATA_W];
`endif
  endfunction

  function automatic logic is_last(
    input logic [IDX_W-1:0] k,
    input logic             dn
  );
    return dn ? (k == '0) : (k == K_MAX);
  endfunction

  state_t           state;
  logic             dir;
  logic [IDX_W-1:0] k_first;
  logic [IDX_W-1:0] k_next;

  assign k_first = descend ? K_MAX : '0;
  assign k_next  = dir ? out_idx - IDX_W'(1)
                       : out_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dir       <= descend;
            out_idx   <= k_first;
            out_data  <= coef(k_first);
            out_last  <= is_last(k_first, descend);
            busy      <= 1'b1;
            out_valid <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_idx  <= k_next;
              out_data <= coef(k_next);
              out_last <= is_last(k_next, dir);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
